// File: rtl/alu_gcd_datapath.sv
// Execution stage: captures opcode/operands on enable and performs ADD, SUB or iterative GCD.
// Optional macro GCD_ITER_COUNT_EN adds an iter_count output counting GCD subtractions.
module alu_gcd_datapath #(
    parameter int WIDTH = 16,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       opcode,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
`ifdef GCD_ITER_COUNT_EN
    output logic [7:0]       iter_count,
`endif
    output logic             op_error
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_GCD = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OPW-1:0]     r_x;
    logic [OPW-1:0]     w_x_nxt;
    logic [OPW-1:0]     r_y;
    logic [OPW-1:0]     w_y_nxt;
    logic [3:0]         r_op;
    logic [3:0]         w_op_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_err;
    logic               w_err_nxt;
`ifdef GCD_ITER_COUNT_EN
    logic [7:0]         r_iter;
    logic [7:0]         w_iter_nxt;
`endif

    function automatic logic [WIDTH-1:0] zext(input logic [OPW-1:0] v);
        logic [WIDTH-1:0] r;
        r         = '0;
        r[OPW-1:0] = v;
        return r;
    endfunction

    // Arithmetic is done at full result width so SUB wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] add_wide(input logic [OPW-1:0] x, input logic [OPW-1:0] y);
        return zext(x) + zext(y);
    endfunction

    function automatic logic [WIDTH-1:0] sub_wide(input logic [OPW-1:0] x, input logic [OPW-1:0] y);
        return zext(x) - zext(y);
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_err_nxt    = r_err;
`ifdef GCD_ITER_COUNT_EN
        w_iter_nxt   = r_iter;
`endif
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_x_nxt     = a;
                    w_y_nxt     = b;
                    w_op_nxt    = opcode;
                    w_busy_nxt  = 1'b1;
`ifdef GCD_ITER_COUNT_EN
                    w_iter_nxt  = 8'd0;
`endif
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                case (r_op)
                    OP_ADD: begin
                        w_result_nxt = add_wide(r_x, r_y);
                        w_err_nxt    = 1'b0;
                        w_state_nxt  = S_DONE;
                    end
                    OP_SUB: begin
                        w_result_nxt = sub_wide(r_x, r_y);
                        w_err_nxt    = 1'b0;
                        w_state_nxt  = S_DONE;
                    end
                    OP_GCD: begin
                        w_err_nxt = 1'b0;
                        if (r_y == '0) begin
                            w_result_nxt = zext(r_x);
                            w_state_nxt  = S_DONE;
                        end else if (r_x == '0) begin
                            w_result_nxt = zext(r_y);
                            w_state_nxt  = S_DONE;
                        end else if (r_x == r_y) begin
                            w_result_nxt = zext(r_x);
                            w_state_nxt  = S_DONE;
                        end else begin
                            // One subtraction per cycle; stay in CALC until a terminal case hits.
                            if (r_x > r_y) begin
                                w_x_nxt = r_x - r_y;
                            end else begin
                                w_y_nxt = r_y - r_x;
                            end
`ifdef GCD_ITER_COUNT_EN
                            w_iter_nxt = r_iter + 8'd1;
`endif
                        end
                    end
                    default: begin
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                endcase
                if (w_state_nxt == S_DONE) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // Wait for enable to drop so a still-high request is not re-executed.
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            r_iter   <= 8'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_op     <= w_op_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_err_nxt;
`ifdef GCD_ITER_COUNT_EN
            r_iter   <= w_iter_nxt;
`endif
        end
    end

    assign result   = r_result;
    assign done     = r_done;
    assign busy     = r_busy;
    assign op_error = r_err;
`ifdef GCD_ITER_COUNT_EN
    assign iter_count = r_iter;
`endif

endmodule

// File: tb/tb_alu_gcd_datapath.sv
// Directed bench for alu_gcd_datapath: ADD/SUB/GCD results, latency, error flag, hold and reset abort.
module tb_alu_gcd_datapath;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  opcode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        op_error;
`ifdef GCD_ITER_COUNT_EN
    logic [7:0]  iter_count;
`endif

    int checks = 0;
    int errors = 0;

    alu_gcd_datapath #(.WIDTH(16), .OPW(8)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .opcode(opcode),
        .a(a),
        .b(b),
        .result(result),
        .done(done),
        .busy(busy),
`ifdef GCD_ITER_COUNT_EN
        .iter_count(iter_count),
`endif
        .op_error(op_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation with enable held until done, then returns to IDLE.
    // lat is the cycle (1 = first cycle after capture edge) in which done was seen, -1 on timeout.
    task automatic do_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                         input int max_cyc, output int lat, output logic [15:0] res,
                         output logic err, output int busy_cnt);
        int cyc;
        lat = -1;
        busy_cnt = 0;
        res = '0;
        err = 1'b0;
        cyc = 0;
        opcode = op;
        a = av;
        b = bv;
        enable = 1'b1;
        while (lat < 0 && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_cnt++;
            if (done) begin
                lat = cyc;
                res = result;
                err = op_error;
            end
        end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        opcode = 4'd0;
        a = 8'd0;
        b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (op_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", op_error); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL reset_iter got %0d exp 0", iter_count); end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat; logic [15:0] res; logic err; int bc;
        do_op(4'b0001, 8'd200, 8'd100, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h012C) begin errors++; $display("FAIL add_result got %h exp 012c", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", err); end
        checks++; if (bc !== 1) begin errors++; $display("FAIL add_busy_cycles got %0d exp 1", bc); end
        checks++; if (result !== 16'h012C) begin errors++; $display("FAIL add_result_held got %h exp 012c", result); end
    endtask

    task automatic test_sub();
        int lat; logic [15:0] res; logic err; int bc;
        do_op(4'b0010, 8'd5, 8'd10, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sub_neg_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'hFFFB) begin errors++; $display("FAIL sub_neg_result got %h exp fffb", res); end
        do_op(4'b0010, 8'd10, 8'd5, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sub_pos_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h0005) begin errors++; $display("FAIL sub_pos_result got %h exp 0005", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sub_err got %b exp 0", err); end
    endtask

    task automatic test_gcd();
        int lat; logic [15:0] res; logic err; int bc;
        do_op(4'b0011, 8'd48, 8'd18, 40, lat, res, err, bc);
        checks++; if (lat !== 6) begin errors++; $display("FAIL gcd48_18_latency got %0d exp 6", lat); end
        checks++; if (res !== 16'h0006) begin errors++; $display("FAIL gcd48_18_result got %h exp 0006", res); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL gcd48_18_busy_cycles got %0d exp 5", bc); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 8'd4) begin errors++; $display("FAIL gcd48_18_iter got %0d exp 4", iter_count); end
`endif
        do_op(4'b0011, 8'd0, 8'd0, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL gcd0_0_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL gcd0_0_result got %h exp 0000", res); end
        do_op(4'b0011, 8'd0, 8'd9, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL gcd0_9_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h0009) begin errors++; $display("FAIL gcd0_9_result got %h exp 0009", res); end
        do_op(4'b0011, 8'd9, 8'd0, 20, lat, res, err, bc);
        checks++; if (res !== 16'h0009) begin errors++; $display("FAIL gcd9_0_result got %h exp 0009", res); end
        do_op(4'b0011, 8'd255, 8'd1, 400, lat, res, err, bc);
        checks++; if (lat !== 256) begin errors++; $display("FAIL gcd255_1_latency got %0d exp 256", lat); end
        checks++; if (res !== 16'h0001) begin errors++; $display("FAIL gcd255_1_result got %h exp 0001", res); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 8'd254) begin errors++; $display("FAIL gcd255_1_iter got %0d exp 254", iter_count); end
`endif
    endtask

    task automatic test_invalid();
        int lat; logic [15:0] res; logic err; int bc;
        do_op(4'b1011, 8'd3, 8'd4, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL inv_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL inv_result got %h exp 0000", res); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_err got %b exp 1", err); end
        checks++; if (op_error !== 1'b1) begin errors++; $display("FAIL inv_err_held got %b exp 1", op_error); end
        do_op(4'b0001, 8'd1, 8'd1, 20, lat, res, err, bc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL inv_then_add_err got %b exp 0", err); end
        checks++; if (res !== 16'h0002) begin errors++; $display("FAIL inv_then_add_result got %h exp 0002", res); end
    endtask

    task automatic test_back_to_back();
        int lat; int cyc; int dcount; int bcount; logic [15:0] res; logic err; int bc;
        opcode = 4'b0001; a = 8'd7; b = 8'd8; enable = 1'b1;
        lat = -1; cyc = 0;
        while (lat < 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done) lat = cyc;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first_latency got %0d exp 2", lat); end
        // Change operands while enable stays high: nothing may be re-captured.
        a = 8'd50; b = 8'd60;
        dcount = 0; bcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
            if (busy) bcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d exp 0", dcount); end
        checks++; if (bcount !== 0) begin errors++; $display("FAIL b2b_recapture_busy got %0d exp 0", bcount); end
        checks++; if (result !== 16'h000F) begin errors++; $display("FAIL b2b_result_held got %h exp 000f", result); end
        enable = 1'b0;
        @(posedge clk); #1;
        do_op(4'b0010, 8'd20, 8'd3, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_second_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h0011) begin errors++; $display("FAIL b2b_second_result got %h exp 0011", res); end
    endtask

    task automatic test_reset_mid();
        int lat; int dcount; logic [15:0] res; logic err; int bc;
        opcode = 4'b0011; a = 8'd200; b = 8'd3; enable = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rmid_result got %h exp 0000", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
        reset = 1'b0;
        enable = 1'b0;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL rmid_activity_after got %0d exp 0", dcount); end
        do_op(4'b0001, 8'd100, 8'd55, 20, lat, res, err, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rmid_add_latency got %0d exp 2", lat); end
        checks++; if (res !== 16'h009B) begin errors++; $display("FAIL rmid_add_result got %h exp 009b", res); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_gcd();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
